// File: rtl/program_sequencer_if.sv
// Program-memory fetch bus between the sequencer and its ROM.
// The sequencer is the master; the ROM answers with data/valid.
interface program_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] ROM_ADDR;
    logic            ROM_RD;
    logic [5:0]      ROM_DATA;
    logic            ROM_VALID;

    modport master (
        output ROM_ADDR, ROM_RD,
        input  ROM_DATA, ROM_VALID
    );

    modport slave (
        input  ROM_ADDR, ROM_RD,
        output ROM_DATA, ROM_VALID
    );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/decode/execute controller for the accumulator datapath.
// Gates decoder enables so each instruction commits exactly once.
module program_sequencer #(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 256
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic                STEP,
    input  logic                STOP,
    program_sequencer_if.master rom,
    output logic [5:0]          IR,
    input  logic                ACC_CE_IN,
    input  logic [2:0]          RF_SEL_IN,
    output logic                ACC_CE_OUT,
    output logic [2:0]          RF_SEL_OUT,
    output logic                EXEC,
    output logic                BUSY,
    output logic                HALTED,
    output logic [15:0]         INSTR_CNT
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC
    } state_t;

    localparam logic [PC_W-1:0] LAST = PC_W'(PROG_LEN - 1);
    localparam logic [5:0]      NOP  = 6'b111100;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic            stop_q, stop_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [5:0]      ir_q, ir_d;
    logic            halted_q, halted_d;
    logic [15:0]     cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            stop_q   <= 1'b0;
            pc_q     <= '0;
            ir_q     <= NOP;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            stop_q   <= stop_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        stop_d   = stop_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (START) begin
                    run_d    = 1'b1;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end else if (STEP) begin
                    run_d    = 1'b0;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (STOP) stop_d = 1'b1;
                if (rom.ROM_VALID) begin
                    ir_d    = rom.ROM_DATA;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (STOP) stop_d = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Leaving EXECUTE always lands in FETCH with no stop or in IDLE
                stop_d = 1'b0;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                if (pc_q == LAST) begin
                    pc_d     = '0;
                    halted_d = 1'b1;
                    run_d    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    if (run_q && !stop_q && !STOP) state_d = S_FETCH;
                    else                           state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom.ROM_ADDR = pc_q;
    assign rom.ROM_RD   = (state_q == S_FETCH);
    assign EXEC         = (state_q == S_EXEC);
    assign BUSY         = (state_q != S_IDLE);
    assign ACC_CE_OUT   = ACC_CE_IN & EXEC;
    assign RF_SEL_OUT   = RF_SEL_IN & {3{EXEC}};
    assign IR           = ir_q;
    assign HALTED       = halted_q;
    assign INSTR_CNT    = cnt_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer against an
// instruction-level model of fetch, execute, stop and halt.
module tb_program_sequencer;
    localparam int PC_W     = 8;
    localparam int PROG_LEN = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, step, stop;
    logic        rom_valid;
    logic [5:0]  junk;
    logic        acc_in;
    logic [2:0]  rf_in;
    logic [5:0]  ir_o;
    logic        acc_o, exec_o, busy_o, halted_o;
    logic [2:0]  rf_o;
    logic [15:0] cnt_o;
    logic [5:0]  rom [256];

    int vectors     = 0;
    int miscompares = 0;

    int pc, cnt, halted;
    logic [5:0] ir;

    program_sequencer_if #(.PC_W(PC_W)) rom_bus ();

    assign rom_bus.ROM_VALID = rom_valid;
    assign rom_bus.ROM_DATA  = rom_valid ? rom[rom_bus.ROM_ADDR] : junk;

    program_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .START      (start),
        .STEP       (step),
        .STOP       (stop),
        .rom        (rom_bus),
        .IR         (ir_o),
        .ACC_CE_IN  (acc_in),
        .RF_SEL_IN  (rf_in),
        .ACC_CE_OUT (acc_o),
        .RF_SEL_OUT (rf_o),
        .EXEC       (exec_o),
        .BUSY       (busy_o),
        .HALTED     (halted_o),
        .INSTR_CNT  (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pc = 0; cnt = 0; halted = 0; ir = 6'b111100;
    endtask

    task automatic rand_inputs();
        acc_in = 1'($urandom);
        rf_in  = 3'($urandom);
        junk   = 6'($urandom);
        start  = 1'($urandom);
        step   = 1'($urandom);
        stop   = 1'($urandom);
    endtask

    task automatic chk_all(input bit busy, input bit rd, input bit ex);
        chk("rom_rd", 32'(rom_bus.ROM_RD), 32'(rd));
        chk("rom_addr", 32'(rom_bus.ROM_ADDR), 32'(pc));
        chk("exec", 32'(exec_o), 32'(ex));
        chk("busy", 32'(busy_o), 32'(busy));
        chk("acc_ce", 32'(acc_o), ex ? 32'(acc_in) : 32'd0);
        chk("rf_sel", 32'(rf_o), ex ? 32'(rf_in) : 32'd0);
        chk("ir", 32'(ir_o), 32'(ir));
        chk("halted", 32'(halted_o), 32'(halted));
        chk("instr_cnt", 32'(cnt_o), 32'(cnt));
    endtask

    // One IDLE cycle; returns 1 when the sequencer was launched.
    task automatic idle_cycle(input bit force_go, input bit go_start,
                              output bit go, output bit run);
        rand_inputs();
        rom_valid = 1'($urandom);
        if (force_go) begin
            start = go_start;
            step  = ~go_start | 1'($urandom);
        end else if ($urandom % 3 != 0) begin
            start = 1'b0;
            step  = 1'b0;
        end
        #1;
        chk_all(1'b0, 1'b0, 1'b0);
        go  = start | step;
        run = start;
        @(posedge clk);
        if (go) halted = 0;
        @(negedge clk);
    endtask

    // stop_sel: -1 none, -2 random cycle, -3 the DECODE cycle
    task automatic do_instr(input bit run, input int stop_sel,
                            output bit more);
        int  waits, stop_c;
        bit  stopped;
        waits = ($urandom % 3 == 0) ? $urandom_range(1, 4) : 0;
        if (stop_sel == -3)      stop_c = waits + 1;
        else if (stop_sel == -2) stop_c = ($urandom % 5 == 0) ?
                                          $urandom_range(0, waits + 2) : -1;
        else                     stop_c = stop_sel;
        stopped = 1'b0;
        more    = 1'b0;
        for (int c = 0; c <= waits + 2; c++) begin
            bit f, ex;
            f  = (c <= waits);
            ex = (c == waits + 2);
            rand_inputs();
            rom_valid = f ? (c == waits) : 1'($urandom);
            stop      = (c == stop_c);
            #1;
            chk_all(1'b1, f, ex);
            if (stop) stopped = 1'b1;
            @(posedge clk);
            if (c == waits) ir = rom[pc];
            if (ex) begin
                if (cnt != 16'hFFFF) cnt++;
                if (pc == PROG_LEN - 1) begin
                    pc = 0;
                    halted = 1;
                end else begin
                    pc++;
                    more = run && !stopped;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic program_run(input bit directed);
        bit go, run, more;
        int k;
        go = 1'b0;
        for (int i = 0; i < 4 && !go; i++)
            idle_cycle(directed || i == 3, directed || 1'($urandom), go, run);
        k = pc;
        more = 1'b1;
        for (int n = 0; n < 2 * PROG_LEN && more; n++) begin
            do_instr(run, (directed && k == 5) ? -3 : -2, more);
            k++;
        end
    endtask

    initial begin
        bit go, run, more;
        for (int i = 0; i < 256; i++) rom[i] = 6'($urandom);
        rst = 1'b1;
        start = 0; step = 0; stop = 0; rom_valid = 1;
        acc_in = 1; rf_in = 3'b111; junk = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_all(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // continuous run from 0, stop in DECODE of instruction 5
        program_run(1'b1);
        chk("stop_pc", 32'(rom_bus.ROM_ADDR), 32'd6);
        chk("stop_cnt", 32'(cnt_o), 32'd6);
        // resume from 6 and run to the end of program
        program_run(1'b0);

        for (int p = 0; p < 40; p++) program_run(1'b0);

        // reset while waiting on ROM data mid-fetch
        idle_cycle(1'b1, 1'b1, go, run);
        do_instr(run, -1, more);
        for (int c = 0; c < 2; c++) begin
            rand_inputs();
            rom_valid = 1'b0;
            #1;
            chk_all(1'b1, 1'b1, 1'b0);
            @(negedge clk);
        end
        rom_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all(1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            rom_valid = 1'b1;
            #1;
            chk_all(1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 10; p++) program_run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/decode/execute controller for the accumulator datapath. It fetches 6-bit instructions (4-bit opcode, 2-bit register address) from program memory using a PC. It presents the latched instruction to the instruction decoder, then qualifies the decoder's ACC_CE and RF_SEL so that the accumulator and register file update exactly once per instruction. Run, single-step and stop controls come from the top level or debug logic.

## Interface
- PC_W, 8: program counter width.
- PROG_LEN, 256: number of program words; the last address is PROG_LEN-1, and PROG_LEN ≤ 2^PC_W.

- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins continuous run (sampled in IDLE only).
- STEP  in  1  one-cycle pulse; executes exactly one instruction (sampled in IDLE only).
- STOP  in  1  level or pulse; requests stop after the current instruction.
- ROM_ADDR  out  PC_W  fetch address; equals PC.
- ROM_RD  out  1  fetch request; held high through FETCH.
- ROM_DATA  in  6  instruction word; valid when ROM_VALID=1.
- ROM_VALID  in  1  fetch data valid; may be tied high.
- IR  out  6  instruction register; drives decoder DATA.
- ACC_CE_IN  in  1  decoder ACC_CE.
- RF_SEL_IN  in  3  decoder RF_SEL.
- ACC_CE_OUT  out  1  ACC_CE_IN gated by EXEC.
- RF_SEL_OUT  out  3  RF_SEL_IN gated by EXEC (bitwise AND).
- EXEC  out  1  one-cycle execute strobe.
- BUSY  out  1  high in any state other than IDLE.
- HALTED  out  1  sticky; set when the instruction at PROG_LEN-1 executes.
- INSTR_CNT  out  16  count of executed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE. Internal run flag RUN records continuous mode.
- IDLE:
  - START=1 → RUN←1, go to FETCH, clear HALTED.
  - Otherwise STEP=1 → RUN←0, go to FETCH, clear HALTED.
  - START has priority when both are asserted.
  - STOP is ignored in IDLE.
- FETCH:
  - ROM_RD=1 and ROM_ADDR=PC.
  - Stay while ROM_VALID=0.
  - On ROM_VALID=1, IR←ROM_DATA and go to DECODE.
- DECODE: one cycle. The decoder and register-file read settle; all outputs except IR/BUSY remain inert.
- EXECUTE: one cycle.
  - EXEC=1, ACC_CE_OUT=ACC_CE_IN, RF_SEL_OUT=RF_SEL_IN.
  - INSTR_CNT←INSTR_CNT+1, saturating at 16'hFFFF.
  - If PC=PROG_LEN-1: PC←0, HALTED←1, RUN←0, next state IDLE.
  - Otherwise PC←PC+1. Next state is FETCH if RUN=1 and no stop is pending; otherwise IDLE.
- Stop pending: set by STOP=1 in any FETCH, DECODE or EXECUTE cycle. It is cleared on entering IDLE. A stop never aborts an in-flight instruction.
- Opcode 4'b1111 (NOP) passes through all states. The decoder drives zero enables, so only the PC and INSTR_CNT advance.
- Outside EXECUTE, ACC_CE_OUT=0 and RF_SEL_OUT=3'b000 regardless of decoder inputs.

## Timing
- Reset values:
  - State=IDLE, RUN=0, stop pending=0, PC=0.
  - IR=6'b111100 (NOP, decoder inert).
  - ROM_RD=0, EXEC=0, ACC_CE_OUT=0, RF_SEL_OUT=0, BUSY=0, HALTED=0, INSTR_CNT=0.
- RESET asserted in any state, including mid-FETCH with ROM_RD high, forces the reset values immediately. No partial execute occurs.
- START sampled at edge n → FETCH during cycle n+1.
- With ROM_VALID tied high, each instruction takes 3 cycles: FETCH, DECODE, EXECUTE. Back-to-back run executes one instruction every 3 cycles.
- Each cycle of ROM_VALID=0 in FETCH adds one cycle. IR changes only at the edge ending FETCH.
- EXEC is high for exactly one cycle per instruction. PC and INSTR_CNT update at the edge ending EXECUTE.
- STOP asserted in the EXECUTE cycle of instruction k → IDLE next cycle; instruction k+1 is not fetched.

## Test plan
- Reset: after RESET, check all outputs at their reset values and IR=6'b111100. Then START with ROM_VALID=1 → ROM_RD=1 one cycle later with ROM_ADDR=0.
- Single step: ROM[0]=6'b000001 (ADD R1), decoder ACC_CE_IN=1. STEP → EXEC high in cycle 3 only, ACC_CE_OUT=1 in that cycle only, then IDLE with PC=1 and INSTR_CNT=1.
- Continuous run with store: ROM[0..2]={6'b011100, 6'b011101, 6'b111100}, ROM_VALID=1. START → EXEC at cycles 3, 6 and 9. RF_SEL_OUT=3'b001 at cycle 3 and 3'b010 at cycle 6, zero elsewhere.
- Wait states: ROM_VALID low for 4 cycles of each fetch → 7 cycles per instruction. IR is stable until ROM_VALID, and ROM_RD stays high throughout FETCH.
- STOP mid-run: pulse STOP during the DECODE of instruction 5 → instruction 5 executes, then IDLE with PC=6 and INSTR_CNT=6. A following START resumes at address 6.
- End of program and reset mid-fetch:
  - PROG_LEN=4, START → after 4 EXECs, HALTED=1, PC=0, IDLE.
  - Assert RESET during a FETCH with ROM_VALID low → IDLE immediately, EXEC never pulses.
